alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NUMBITS, default 16, operand/result width in bits.
REQ-002 Parameter SETTLE, default 1, range 1-15, cycles the ALU inputs are held before capture.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command FIFO can accept.
REQ-007 cmd_opcode  in  3  ALU operation (000 uadd, 001 sadd, 010 usub, 011 ssub, 100 and, 101 or, 110 xor, 111 shr1).
REQ-008 cmd_a, cmd_b  in  NUMBITS each  operands.
REQ-009 cmd_chain  in  1  replace cmd_a with the previously captured result.
REQ-010 alu_opcode  out  3; alu_a, alu_b  out  NUMBITS each  registered drive to the external ALU.
REQ-011 alu_result  in  NUMBITS; alu_carryout, alu_overflow, alu_zero  in  1 each  ALU outputs.
REQ-012 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-013 rsp_result  out  NUMBITS; rsp_carryout, rsp_overflow, rsp_zero  out  1 each  captured response.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Command FIFO depth 4, storing {opcode, a, b, chain}; push on cmd_valid && cmd_ready.
REQ-016 cmd_ready = !full, derived from registered count only; a push while full is dropped even if a pop occurs in the same cycle.
REQ-017 FSM states IDLE, SETTLE, RESP.
REQ-018 IDLE: FIFO non-empty -> pop head, load alu_opcode/alu_a/alu_b, load settle counter with SETTLE, go SETTLE.
REQ-019 Chained pop: alu_a loaded from prev_result instead of the stored a.
REQ-020 SETTLE: counter decrements each cycle; in the cycle it reads 1, capture alu_result and flags into the rsp registers and prev_result, assert rsp_valid next cycle, go RESP.
REQ-021 Latency: rsp_valid asserts exactly SETTLE+1 cycles after the pop cycle.
REQ-022 RESP: rsp_valid and rsp fields held stable until rsp_valid && rsp_ready; then rsp_valid drops next cycle and FSM returns to IDLE (one bubble before next pop).
REQ-023 alu_* outputs hold their last values outside SETTLE.
REQ-024 Pushes are accepted in every state, including RESP under backpressure.
REQ-025 FIFO pointers wrap modulo 4; count range 0-4.

Reset
REQ-026 On reset: FSM to IDLE; FIFO emptied; cmd_ready 1; rsp_valid 0; busy 0; alu_opcode, alu_a, alu_b, rsp_result, prev_result all 0; rsp flags 0.
REQ-027 Reset mid-operation discards the in-flight command and all queued commands without producing a response.

Configuration
REQ-028 Macro ALU_SEQ_STICKY_EN defined: add outputs sticky_carry and sticky_ovf (1 bit each, reset 0) and input sticky_clr (1 bit).
REQ-029 With the macro, sticky_carry/sticky_ovf OR in rsp_carryout/rsp_overflow at capture; sticky_clr clears them; clear and set in the same cycle leaves the bit set.
REQ-030 Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Structure
REQ-031 Shared package alu_pkg holds the 3-bit opcode constants, the opcode type, and the FSM state enum.
REQ-032 FIFO is a sub-module alu_cmd_fifo (parameterised width, depth 4); FSM and capture logic live in alu_seq.

Verification (NUMBITS=8, SETTLE=1, reference ALU instantiated on the alu_* ports)
REQ-033 uadd A=FF B=01 -> rsp_result 00, zero 1, carryout 1, overflow 0, rsp_valid 2 cycles after pop.
REQ-034 sadd A=7F B=01 -> rsp_result 80, overflow 1, carryout 0; with ALU_SEQ_STICKY_EN, sticky_ovf 1 until sticky_clr.
REQ-035 uadd 05+03 then chained shr1 (B ignored) -> responses 08 then 04.
REQ-036 rsp_ready held low 10 cycles, 5 pushes offered -> 4 accepted, cmd_ready 0 on the 5th, first response held stable throughout.
REQ-037 Reset asserted during SETTLE with 3 commands queued -> no response, cmd_ready 1, FIFO empty, alu outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequenced ALU driver:
// opcode encodings, opcode type and controller states.
package alu_pkg;

   localparam int OPCODE_W   = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 4;

   typedef enum logic [OPCODE_W-1:0] {
      OP_UADD = 3'b000,
      OP_SADD = 3'b001,
      OP_USUB = 3'b010,
      OP_SSUB = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_SHR1 = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_RESP
   } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Four-entry command queue; ready/empty come from the
// registered count only, so a push while full is dropped.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             ready,
   output logic             empty
);

   localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [2:0]       count;
   logic             do_push;
   logic             do_pop;

   assign ready   = (count != FULL_CNT);
   assign empty   = (count == 3'd0);
   assign do_push = push && ready;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally at depth 4; count tracks occupancy 0..4.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the count makes stale entries invisible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_seq.sv
// Queues ALU commands, drives an external ALU, waits SETTLE cycles,
// captures its result. Optional ALU_SEQ_STICKY_EN adds sticky flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int NUMBITS = 16,
   parameter int SETTLE  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_opcode,
   input  logic [NUMBITS-1:0] cmd_a,
   input  logic [NUMBITS-1:0] cmd_b,
   input  logic               cmd_chain,
   output logic [2:0]         alu_opcode,
   output logic [NUMBITS-1:0] alu_a,
   output logic [NUMBITS-1:0] alu_b,
   input  logic [NUMBITS-1:0] alu_result,
   input  logic               alu_carryout,
   input  logic               alu_overflow,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [NUMBITS-1:0] rsp_result,
   output logic               rsp_carryout,
   output logic               rsp_overflow,
   output logic               rsp_zero,
   output logic               busy
`ifdef ALU_SEQ_STICKY_EN
   ,
   input  logic               sticky_clr,
   output logic               sticky_carry,
   output logic               sticky_ovf
`endif
);

   localparam int ENTRY_W = OPCODE_W + 2 * NUMBITS + 1;
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

   logic [ENTRY_W-1:0] wdata;
   logic [ENTRY_W-1:0] rdata;
   logic               fifo_empty;
   logic               pop;
   logic               capture;

   opcode_t            head_op;
   logic [NUMBITS-1:0] head_a;
   logic [NUMBITS-1:0] head_b;
   logic               head_chain;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [NUMBITS-1:0] prev_result;

   assign wdata = {cmd_opcode, cmd_a, cmd_b, cmd_chain};

   assign head_op    = opcode_t'(rdata[ENTRY_W-1 -: OPCODE_W]);
   assign head_a     = rdata[2*NUMBITS -: NUMBITS];
   assign head_b     = rdata[NUMBITS -: NUMBITS];
   assign head_chain = rdata[0];

   assign pop     = (state == S_IDLE) && !fifo_empty;
   assign capture = (state == S_SETTLE) && (cnt == CNT_W'(1));

   alu_cmd_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .ready (cmd_ready),
      .empty (fifo_empty)
   );

   // Controller: pop and drive the ALU, count down, capture, hand off.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         cnt          <= '0;
         alu_opcode   <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
         prev_result  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  alu_opcode <= head_op;
                  alu_a      <= head_chain ? prev_result : head_a;
                  alu_b      <= head_b;
                  cnt        <= SETTLE_LD;
                  busy       <= 1'b1;
                  state      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (capture) begin
                  rsp_result   <= alu_result;
                  rsp_carryout <= alu_carryout;
                  rsp_overflow <= alu_overflow;
                  rsp_zero     <= alu_zero;
                  prev_result  <= alu_result;
                  rsp_valid    <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_STICKY_EN
   // Sticky flags accumulate captured flags; a set wins over a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_carry <= 1'b0;
         sticky_ovf   <= 1'b0;
      end else begin
         sticky_carry <= (sticky_carry && !sticky_clr)
                         || (capture && alu_carryout);
         sticky_ovf   <= (sticky_ovf && !sticky_clr)
                         || (capture && alu_overflow);
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (NUMBITS=8, SETTLE=1) with a
// behavioural ALU attached to the alu_* ports.
module tb_alu_seq;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_opcode = 3'd0;
   logic [7:0] cmd_a = 8'd0;
   logic [7:0] cmd_b = 8'd0;
   logic       cmd_chain = 1'b0;
   logic [2:0] alu_opcode;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_result;
   logic       alu_carryout;
   logic       alu_overflow;
   logic       alu_zero;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_result;
   logic       rsp_carryout;
   logic       rsp_overflow;
   logic       rsp_zero;
   logic       busy;
`ifdef ALU_SEQ_STICKY_EN
   logic       sticky_clr = 1'b0;
   logic       sticky_carry;
   logic       sticky_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq #(
      .NUMBITS (8),
      .SETTLE  (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_chain    (cmd_chain),
      .alu_opcode   (alu_opcode),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .alu_overflow (alu_overflow),
      .alu_zero     (alu_zero),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carryout (rsp_carryout),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .busy         (busy)
`ifdef ALU_SEQ_STICKY_EN
      ,
      .sticky_clr   (sticky_clr),
      .sticky_carry (sticky_carry),
      .sticky_ovf   (sticky_ovf)
`endif
   );

   // Reference ALU: {carry, result}; usub carry is the borrow.
   logic [8:0] wide;
   logic       ref_ovf;
   always_comb begin
      wide    = 9'd0;
      ref_ovf = 1'b0;
      case (alu_opcode)
         OP_UADD: wide = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SADD: begin
            wide    = {1'b0, alu_a} + {1'b0, alu_b};
            ref_ovf = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
         end
         OP_USUB: wide = {1'b0, alu_a} - {1'b0, alu_b};
         OP_SSUB: begin
            wide    = {1'b0, alu_a} - {1'b0, alu_b};
            ref_ovf = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
         end
         OP_AND:  wide = {1'b0, alu_a & alu_b};
         OP_OR:   wide = {1'b0, alu_a | alu_b};
         OP_XOR:  wide = {1'b0, alu_a ^ alu_b};
         default: wide = {alu_a[0], 1'b0, alu_a[7:1]};
      endcase
   end
   assign alu_result   = wide[7:0];
   assign alu_carryout = wide[8];
   assign alu_overflow = ref_ovf;
   assign alu_zero     = (wide[7:0] == 8'd0);

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ch,
                       output logic acc);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_chain  = ch;
      acc        = cmd_ready;
      tick();
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, " vld"}, 32'(rsp_valid), 32'd1);
   endtask

   task automatic take_rsp(input string tag, input logic [7:0] r,
                           input logic c, input logic o, input logic z);
      wait_valid(tag);
      check({tag, " res"}, 32'(rsp_result), 32'(r));
      check({tag, " cvz"},
            32'({rsp_carryout, rsp_overflow, rsp_zero}),
            32'({c, o, z}));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   logic [2:0] bp_op [5];
   logic [7:0] bp_a  [5];
   logic [7:0] bp_b  [5];
   logic [7:0] bp_r  [4];
   logic [2:0] bp_f  [4];

   initial begin
      logic acc;
      int   n_acc;

      bp_op[0] = OP_USUB; bp_a[0] = 8'h09; bp_b[0] = 8'h03;
      bp_op[1] = OP_SSUB; bp_a[1] = 8'h80; bp_b[1] = 8'h01;
      bp_op[2] = OP_AND;  bp_a[2] = 8'hF0; bp_b[2] = 8'h3C;
      bp_op[3] = OP_OR;   bp_a[3] = 8'h0F; bp_b[3] = 8'hF0;
      bp_op[4] = OP_XOR;  bp_a[4] = 8'h5A; bp_b[4] = 8'h5A;
      bp_r[0] = 8'h06; bp_f[0] = 3'b000;
      bp_r[1] = 8'h7F; bp_f[1] = 3'b010;
      bp_r[2] = 8'h30; bp_f[2] = 3'b000;
      bp_r[3] = 8'hFF; bp_f[3] = 3'b000;

      // reset state
      repeat (3) tick();
      reset = 1'b0;
      check("rst ready", 32'(cmd_ready), 32'd1);
      check("rst valid", 32'(rsp_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      check("rst rsp", 32'(rsp_result), 32'd0);

      // uadd FF+01: exact latency, carry and zero
      push(OP_UADD, 8'hFF, 8'h01, 1'b0, acc);
      check("uadd acc", 32'(acc), 32'd1);
      check("uadd busy0", 32'(busy), 32'd0);
      tick();
      check("uadd pop", 32'({busy, rsp_valid}), 32'b10);
      check("uadd drive", 32'({alu_opcode, alu_a, alu_b}),
            32'({3'b000, 8'hFF, 8'h01}));
      tick();
      check("uadd lat", 32'(rsp_valid), 32'd1);
      take_rsp("uadd", 8'h00, 1'b1, 1'b0, 1'b1);
      check("uadd done", 32'({busy, rsp_valid}), 32'd0);

      // sadd 7F+01: signed overflow
      push(OP_SADD, 8'h7F, 8'h01, 1'b0, acc);
      take_rsp("sadd", 8'h80, 1'b0, 1'b1, 1'b0);
`ifdef ALU_SEQ_STICKY_EN
      check("stk set", 32'({sticky_carry, sticky_ovf}), 32'b11);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("stk clr", 32'({sticky_carry, sticky_ovf}), 32'b00);
`endif

      // uadd then chained shr1 (A and B of shr1 ignored)
      push(OP_UADD, 8'h05, 8'h03, 1'b0, acc);
      push(OP_SHR1, 8'h77, 8'hAA, 1'b1, acc);
      take_rsp("chain1", 8'h08, 1'b0, 1'b0, 1'b0);
      take_rsp("chain2", 8'h04, 1'b0, 1'b0, 1'b0);

      // backpressure: one held response, 5 pushes offered
      push(OP_UADD, 8'h10, 8'h20, 1'b0, acc);
      wait_valid("bp0");
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         push(bp_op[i], bp_a[i], bp_b[i], 1'b0, acc);
         check($sformatf("bp acc%0d", i), 32'(acc), 32'(i < 4));
         if (acc) n_acc++;
         check($sformatf("bp hold%0d", i),
               32'({rsp_valid, rsp_result}), 32'({1'b1, 8'h30}));
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp idle%0d", i),
               32'({rsp_valid, rsp_result, cmd_ready}),
               32'({1'b1, 8'h30, 1'b0}));
      end
      check("bp count", 32'(n_acc), 32'd4);
      take_rsp("bp0", 8'h30, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         take_rsp($sformatf("bp%0d", i + 1), bp_r[i],
                  bp_f[i][2], bp_f[i][1], bp_f[i][0]);
      repeat (4) tick();
      check("bp drop", 32'({rsp_valid, busy}), 32'd0);

      // reset during SETTLE with 3 commands queued
      push(OP_XOR, 8'h5A, 8'hA5, 1'b0, acc);
      wait_valid("r0");
      for (int i = 0; i < 4; i++) begin
         push(OP_UADD, 8'(i), 8'h01, 1'b0, acc);
         check($sformatf("r acc%0d", i), 32'(acc), 32'd1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("r hs", 32'(rsp_valid), 32'd0);
      tick();
      check("r settle", 32'({busy, rsp_valid}), 32'b10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("r valid", 32'(rsp_valid), 32'd0);
      check("r ready", 32'(cmd_ready), 32'd1);
      check("r busy", 32'(busy), 32'd0);
      check("r alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      check("r rsp", 32'(rsp_result), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("r quiet%0d", i), 32'({rsp_valid, busy}), 32'd0);
      end
      push(OP_SHR1, 8'hFF, 8'h00, 1'b1, acc);
      take_rsp("r prev", 8'h00, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
